// File: rtl/serial_output_collector.sv
// -----------------------------------------------------------------------------
// serial_output_collector
//
// Serial-in, parallel-out capture register for the Double Dabble datapath.
// Assembles an MSB-first bit stream (raw binary from the input shift register,
// or BCD digits from the BCD shift chain) into a WIDTH-bit word and presents
// it with a valid/ready handshake. If a word completes while the previous one
// is still pending and not being taken, the new word is dropped and a sticky
// overrun flag is raised.
//
// Parameters:
//   WIDTH  bits per captured word (2..32; 12 = three BCD digits, 8 = binary)
//   CNT_W  width of the bit counter; 2**CNT_W must exceed WIDTH
//
// Ports:
//   clk           rising-edge clock
//   clear_bar     asynchronous active-low reset
//   start         one-cycle pulse; begins or restarts a capture
//   serial_in     serial data bit, word MSB first
//   shift_en      qualifies serial_in while capturing
//   out_ready     consumer accepts parallel_out when out_valid=1
//   parallel_out  last completed word, first received bit at [WIDTH-1]
//   out_valid     parallel_out holds an unconsumed word
//   busy          capture in progress
//   bit_count     bits captured so far in the current word
//   overrun       sticky; a word completed while the previous was pending
// -----------------------------------------------------------------------------
module serial_output_collector #(
   parameter int WIDTH = 12,
   parameter int CNT_W = 5
) (
   input  logic             clk,
   input  logic             clear_bar,
   input  logic             start,
   input  logic             serial_in,
   input  logic             shift_en,
   input  logic             out_ready,
   output logic [WIDTH-1:0] parallel_out,
   output logic             out_valid,
   output logic             busy,
   output logic [CNT_W-1:0] bit_count,
   output logic             overrun
);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t state_q, state_d;

   // Only WIDTH-1 bits need to be held: the final bit goes straight from
   // serial_in into the completed word on the last edge.
   logic [WIDTH-2:0] shift_q;
   logic [CNT_W-1:0] cnt_q;
   logic [WIDTH-1:0] par_q;
   logic             valid_q;
   logic             overrun_q;

   logic             qual_bit;
   logic             last_bit;
   logic             restart;
   logic [WIDTH-1:0] word;

   // A qualified bit only exists while capturing; the completion edge wins
   // over a coincident start, so start only restarts on non-final edges.
   assign qual_bit = (state_q == SHIFT) && shift_en;
   assign last_bit = qual_bit && (cnt_q == CNT_W'(WIDTH - 1));
   assign restart  = (state_q == SHIFT) && start && !last_bit;
   assign word     = {shift_q, serial_in};

   // ---------------------------------------------------------------- state reg
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of process evaluation order.
   always_ff @(posedge clk or negedge clear_bar) begin
      if (!clear_bar) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------------------------------------------------- next-state comb
   // NOTE: state_d is defaulted first so no path leaves it unassigned, which
   // would otherwise infer a latch.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (start)    state_d = SHIFT;
         SHIFT:   if (last_bit) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // ---------------------------------------------------------------- datapath
   always_ff @(posedge clk or negedge clear_bar) begin
      if (!clear_bar) begin
         shift_q   <= '0;
         cnt_q     <= '0;
         par_q     <= '0;
         valid_q   <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         // Capture path: start from IDLE and a mid-capture restart both drop
         // any partial bits and whatever bit arrives in that cycle.
         if ((state_q == IDLE && start) || restart || last_bit) begin
            shift_q <= '0;
            cnt_q   <= '0;
         end else if (qual_bit) begin
            shift_q <= word[WIDTH-2:0];
            cnt_q   <= cnt_q + CNT_W'(1);
         end

         // Output path: a completing word may load only if the slot is free
         // now or is being emptied on this same edge.
         if (last_bit) begin
            if (!valid_q || out_ready) begin
               par_q   <= word;
               valid_q <= 1'b1;
            end else begin
               overrun_q <= 1'b1;
            end
         end else if (valid_q && out_ready) begin
            valid_q <= 1'b0;
         end
      end
   end

   // ------------------------------------------------------------- output comb
   // Every output is a direct view of a register; no input reaches an output
   // without passing through a flop.
   always_comb begin
      busy         = (state_q == SHIFT);
      bit_count    = cnt_q;
      parallel_out = par_q;
      out_valid    = valid_q;
      overrun      = overrun_q;
   end

endmodule

// File: tb/tb_serial_output_collector.sv
// -----------------------------------------------------------------------------
// tb_serial_output_collector
//
// Drives an 8-bit and a 12-bit instance of serial_output_collector. Expected
// words are queued when a capture is driven; a monitor per instance pops and
// compares whenever a new word appears on the output.
// -----------------------------------------------------------------------------
module tb_serial_output_collector;

   logic clk = 1'b0;
   logic clear_bar = 1'b1;

   // 8-bit instance
   logic       st8 = 1'b0, sh8 = 1'b0, s8 = 1'b0, rdy8 = 1'b0;
   logic [7:0] par8;
   logic       val8, busy8, ovr8;
   logic [4:0] cnt8;

   // 12-bit instance
   logic        st12 = 1'b0, sh12 = 1'b0, s12 = 1'b0, rdy12 = 1'b1;
   logic [11:0] par12;
   logic        val12, busy12, ovr12;
   logic [4:0]  cnt12;

   int total = 0;
   int bad   = 0;

   logic [7:0]  q8[$];
   logic [11:0] q12[$];

   always #5 clk = ~clk;

   serial_output_collector #(.WIDTH(8), .CNT_W(5)) dut8 (
      .clk          (clk),
      .clear_bar    (clear_bar),
      .start        (st8),
      .serial_in    (s8),
      .shift_en     (sh8),
      .out_ready    (rdy8),
      .parallel_out (par8),
      .out_valid    (val8),
      .busy         (busy8),
      .bit_count    (cnt8),
      .overrun      (ovr8)
   );

   serial_output_collector #(.WIDTH(12), .CNT_W(5)) dut12 (
      .clk          (clk),
      .clear_bar    (clear_bar),
      .start        (st12),
      .serial_in    (s12),
      .shift_en     (sh12),
      .out_ready    (rdy12),
      .parallel_out (par12),
      .out_valid    (val12),
      .busy         (busy12),
      .bit_count    (cnt12),
      .overrun      (ovr12)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // One clock cycle of stimulus on the 8-bit instance; returns 1 time unit
   // after the rising edge so outputs can be sampled.
   task automatic cyc8(input logic st, input logic sh, input logic si, input logic rdy);
      @(negedge clk);
      st8 = st; sh8 = sh; s8 = si; rdy8 = rdy;
      @(posedge clk);
      #1;
   endtask

   task automatic cyc12(input logic st, input logic sh, input logic si);
      @(negedge clk);
      st12 = st; sh12 = sh; s12 = si;
      @(posedge clk);
      #1;
   endtask

   // Full capture on the 8-bit instance: start, then 8 qualified bits; out_ready
   // stays low except on the final bit edge where it is rdy_last.
   task automatic send8(input logic [7:0] w, input logic rdy_last);
      cyc8(1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 7; i >= 0; i--)
         cyc8(1'b0, 1'b1, w[i], (i == 0) ? rdy_last : 1'b0);
   endtask

   // ----------------------------------------------------------------- monitors
   logic       pv8 = 1'b0;
   logic [7:0] po8 = '0;
   always @(negedge clk) begin
      if (val8 && (!pv8 || par8 != po8)) begin
         check("q8_has_entry", 32'(q8.size() != 0), 32'd1);
         if (q8.size() != 0) check("mon8_word", 32'(par8), 32'(q8.pop_front()));
      end
      pv8 = val8;
      po8 = par8;
   end

   logic        pv12 = 1'b0;
   logic [11:0] po12 = '0;
   always @(negedge clk) begin
      if (val12 && (!pv12 || par12 != po12)) begin
         check("q12_has_entry", 32'(q12.size() != 0), 32'd1);
         if (q12.size() != 0) check("mon12_word", 32'(par12), 32'(q12.pop_front()));
      end
      pv12 = val12;
      po12 = par12;
   end

   // ---------------------------------------------------------------- stimulus
   initial begin
      logic [7:0]  pat;
      logic [11:0] pat12;

      // Reset state
      #1 clear_bar = 1'b0;
      #1;
      check("rst_par",  32'(par8),  32'h0);
      check("rst_val",  32'(val8),  32'h0);
      check("rst_busy", 32'(busy8), 32'h0);
      check("rst_cnt",  32'(cnt8),  32'h0);
      check("rst_ovr",  32'(ovr8),  32'h0);
      @(negedge clk);
      clear_bar = 1'b1;

      // A5: counting, busy, completion latency
      pat = 8'hA5;
      q8.push_back(pat);
      cyc8(1'b1, 1'b0, 1'b0, 1'b0);
      check("a5_start_busy", 32'(busy8), 32'h1);
      check("a5_start_cnt",  32'(cnt8),  32'h0);
      for (int i = 7; i >= 0; i--) begin
         cyc8(1'b0, 1'b1, pat[i], 1'b0);
         if (i > 0) begin
            check("a5_cnt",  32'(cnt8),  32'(8 - i));
            check("a5_busy", 32'(busy8), 32'h1);
            check("a5_val",  32'(val8),  32'h0);
         end else begin
            check("a5_done_cnt",  32'(cnt8),  32'h0);
            check("a5_done_busy", 32'(busy8), 32'h0);
            check("a5_done_val",  32'(val8),  32'h1);
            check("a5_done_par",  32'(par8),  32'hA5);
         end
      end
      cyc8(1'b0, 1'b0, 1'b0, 1'b1);
      check("a5_consumed_val", 32'(val8), 32'h0);
      check("a5_hold_par",     32'(par8), 32'hA5);
      cyc8(1'b0, 1'b0, 1'b0, 1'b1);
      check("ready_idle_val", 32'(val8), 32'h0);

      // 5A with start coinciding with completion edge: start is ignored
      pat = 8'h5A;
      q8.push_back(pat);
      cyc8(1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 7; i >= 0; i--)
         cyc8((i == 0), 1'b1, pat[i], 1'b0);
      check("coinc_busy", 32'(busy8), 32'h0);
      check("coinc_par",  32'(par8),  32'h5A);
      cyc8(1'b0, 1'b1, 1'b1, 1'b1);
      check("idle_ignores_cnt", 32'(cnt8), 32'h0);
      check("idle_ignores_val", 32'(val8), 32'h0);

      // 3C with shift_en gaps: count holds, completion only on 8th bit
      pat = 8'h3C;
      q8.push_back(pat);
      cyc8(1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 7; i >= 0; i--) begin
         cyc8(1'b0, 1'b1, pat[i], 1'b0);
         if (i > 0) begin
            for (int g = 0; g < 2; g++) begin
               cyc8(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'b0);
               check("gap_cnt", 32'(cnt8), 32'(8 - i));
               check("gap_val", 32'(val8), 32'h0);
            end
         end
      end
      check("gap_par", 32'(par8), 32'h3C);
      check("gap_val_done", 32'(val8), 32'h1);
      cyc8(1'b0, 1'b0, 1'b0, 1'b1);

      // Restart: 5 bits discarded, then F0
      pat = 8'hF0;
      q8.push_back(pat);
      cyc8(1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) cyc8(1'b0, 1'b1, 1'b1, 1'b0);
      check("pre_restart_cnt", 32'(cnt8), 32'h5);
      cyc8(1'b1, 1'b1, 1'b1, 1'b0);
      check("restart_cnt",  32'(cnt8),  32'h0);
      check("restart_busy", 32'(busy8), 32'h1);
      for (int i = 7; i >= 0; i--) cyc8(1'b0, 1'b1, pat[i], 1'b0);
      check("restart_par", 32'(par8), 32'hF0);
      cyc8(1'b0, 1'b0, 1'b0, 1'b1);

      // Overrun: 11 pending, 22 dropped, 33 loads on a consuming edge
      q8.push_back(8'h11);
      send8(8'h11, 1'b0);
      check("ovr_first_val", 32'(val8), 32'h1);
      check("ovr_first_ovr", 32'(ovr8), 32'h0);
      send8(8'h22, 1'b0);
      check("ovr_drop_par", 32'(par8), 32'h11);
      check("ovr_drop_ovr", 32'(ovr8), 32'h1);
      check("ovr_drop_val", 32'(val8), 32'h1);
      q8.push_back(8'h33);
      send8(8'h33, 1'b1);
      check("ovr_swap_par", 32'(par8), 32'h33);
      check("ovr_swap_val", 32'(val8), 32'h1);
      check("ovr_sticky",   32'(ovr8), 32'h1);

      // Asynchronous reset mid-capture
      cyc8(1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) cyc8(1'b0, 1'b1, 1'b1, 1'b0);
      #2 clear_bar = 1'b0;
      #1;
      check("arst_par",  32'(par8),  32'h0);
      check("arst_val",  32'(val8),  32'h0);
      check("arst_busy", 32'(busy8), 32'h0);
      check("arst_cnt",  32'(cnt8),  32'h0);
      check("arst_ovr",  32'(ovr8),  32'h0);
      @(negedge clk);
      clear_bar = 1'b1;
      q8.push_back(8'h81);
      send8(8'h81, 1'b0);
      check("post_rst_par", 32'(par8), 32'h81);
      check("post_rst_ovr", 32'(ovr8), 32'h0);
      cyc8(1'b0, 1'b0, 1'b0, 1'b1);

      // 12-bit BCD 255 with out_ready held high: valid for exactly one cycle
      pat12 = 12'h255;
      q12.push_back(pat12);
      cyc12(1'b1, 1'b0, 1'b0);
      for (int i = 11; i >= 0; i--) cyc12(1'b0, 1'b1, pat12[i]);
      check("bcd_par",  32'(par12),  32'h255);
      check("bcd_val",  32'(val12),  32'h1);
      check("bcd_busy", 32'(busy12), 32'h0);
      cyc12(1'b0, 1'b0, 1'b0);
      check("bcd_val_one_cycle", 32'(val12), 32'h0);
      check("bcd_hold_par",      32'(par12), 32'h255);

      repeat (3) cyc8(1'b0, 1'b0, 1'b0, 1'b0);
      check("q8_drained",  32'(q8.size()),  32'h0);
      check("q12_drained", 32'(q12.size()), 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
